matrix_loader: RTL and testbench
================================

Name: matrix_loader

Overview:
Upstream stage of the matrix multiply unit. Accepts signed 8-bit elements one per beat over a valid/ready stream and assembles operand matrices A then B. Output is in compact row-major packed form, sized by matrix_size, and drives the multiplier's raw_matrix_a / raw_matrix_b inputs directly. Signals completion so the control FSM can sample the combinational product.

Parameters:
ELEM_W, 8, element width in bits (signed two's complement)
MAX_DIM, 5, maximum matrix dimension; packed bus width = MAX_DIM*MAX_DIM*ELEM_W = 200

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  begin a new load of A then B; honoured only in IDLE
abort  in  1  synchronous abort; returns to IDLE from any state
matrix_size  in  2  00:2x2, 01:3x3, 10:4x4, 11:5x5; latched on accepted start
in_valid  in  1  in_data carries a valid element
in_data  in  8  signed element, row-major order, A elements first then B
in_ready  out  1  loader can accept an element this cycle
raw_matrix_a  out  200  packed A; element n at bits [n*8 +: 8], n = row*N + col
raw_matrix_b  out  200  packed B; same packing
size_out  out  2  latched matrix_size, forwarded to the multiplier
busy  out  1  high in LOAD_A or LOAD_B
done  out  1  one-cycle pulse when the last B element has been stored
matrices_valid  out  1  high from done until the next accepted start or abort

Behaviour:
- Reset (async, active-high): state=IDLE; raw_matrix_a, raw_matrix_b, size_out, count = 0; in_ready, busy, done, matrices_valid = 0.
- N = matrix_size + 2. Element count E = N*N: 4, 9, 16, 25.
- States: IDLE, LOAD_A, LOAD_B, DONE.
- IDLE: in_ready=0. On start=1 (and abort=0):
  - latch size_out.
  - clear both matrices to zero.
  - count=0, matrices_valid=0.
  - next state LOAD_A.
- LOAD_A / LOAD_B: in_ready=1, busy=1. A beat is accepted when in_valid && in_ready.
  - On acceptance, in_data is written to element slot count; count increments.
  - in_valid=0 holds state; bubbles are allowed anywhere.
- LOAD_A: an accepted beat with count==E-1 sets count=0 and moves to LOAD_B.
- LOAD_B: an accepted beat with count==E-1 moves to DONE.
- DONE: lasts one cycle. done=1, matrices_valid is set, in_ready=0. Next state IDLE.
- Latency: done is asserted the cycle after the final B beat is accepted. Outputs are stable from that cycle on.
- Slots at n >= E stay zero. Packing is compact (stride N), not stride 5; the multiplier's masker expands it.
- start outside IDLE is ignored. matrix_size changes outside IDLE have no effect.
- abort: highest priority after reset, in any state. Effects:
  - next state IDLE, count=0, matrices_valid=0, done=0.
  - matrix contents are retained but undefined for use.
  - abort and start in the same IDLE cycle: abort wins and start is dropped.
- Reset mid-load: everything returns to reset values immediately.
- in_data is stored verbatim; no saturation or range checks.
- Outputs come directly from registers; there is no combinational path from in_valid to in_ready.

Decomposition:
- Shared package (matrix_pkg):
  - ELEM_W, MAX_DIM, PACKED_W=200.
  - size encodings SZ_2X2..SZ_5X5.
  - a function dim_elems(size) returning E.
  - loader state encoding.
- One natural sub-module: matrix_slot_writer, which writes 8 bits into a 200-bit register at a runtime index with a clear input. It is instantiated twice (A and B), and keeps the FSM file small.

Test Plan:
- 2x2 load: start with size=00; stream 1,2,3,4 then 5,6,7,8 with in_valid held high. Required response:
  - raw_matrix_a[31:0]=0x04030201 and raw_matrix_b[31:0]=0x08070605.
  - all higher bits zero.
  - done pulses exactly 9 cycles after start (1 + 8 beats).
- 5x5 with bubbles: size=11; drive elements 0..24 for A and -1 (0xFF) x25 for B, with in_valid toggling every other cycle. Required response:
  - raw_matrix_a[199:192]=24 and every B byte = 0xFF.
  - done occurs once; busy stays high throughout the load.
- Abort mid-load: size=01; accept 5 A beats, then pulse abort. Required response:
  - next cycle state is IDLE with in_ready=0 and matrices_valid=0.
  - a new start with size=00 loads correctly and clears the stale bytes.
- Start ignored while busy: pulse start with size=10 during LOAD_B of a 3x3 load. Required response: size_out stays 01 and B completes after 9 elements.
- Async reset mid-load: assert reset between clock edges during LOAD_A. Required response:
  - all outputs are zero before the next edge.
  - after release, in_ready=0 until start.
- Back-to-back: start is asserted in the cycle right after done. Required response:
  - accepted on the IDLE cycle following DONE.
  - matrices_valid drops and both matrices are cleared.

Source files
------------

// File: rtl/matrix_loader_pkg.sv
// matrix_pkg: shared widths, size codes, loader states and element-count helper
package matrix_pkg;
  localparam int ELEM_W   = 8;
  localparam int MAX_DIM  = 5;
  localparam int PACKED_W = MAX_DIM * MAX_DIM * ELEM_W;
  localparam logic [1:0] SZ_2X2 = 2'd0;
  localparam logic [1:0] SZ_3X3 = 2'd1;
  localparam logic [1:0] SZ_4X4 = 2'd2;
  localparam logic [1:0] SZ_5X5 = 2'd3;
  typedef enum logic [1:0] {S_IDLE, S_LOAD_A, S_LOAD_B, S_DONE} ld_state_t;
  function automatic logic [4:0] dim_elems(input logic [1:0] sz);
    return sz == SZ_2X2 ? 5'd4 : sz == SZ_3X3 ? 5'd9 : sz == SZ_4X4 ? 5'd16 : 5'd25;
  endfunction
endpackage

// File: rtl/matrix_loader_if.sv
// matrix_loader_if: element stream, control and packed-matrix outputs of the loader
interface matrix_loader_if;
  import matrix_pkg::*;
  logic                start;
  logic                abort;
  logic [1:0]          matrix_size;
  logic                in_valid;
  logic [ELEM_W-1:0]   in_data;
  logic                in_ready;
  logic [PACKED_W-1:0] raw_matrix_a;
  logic [PACKED_W-1:0] raw_matrix_b;
  logic [1:0]          size_out;
  logic                busy;
  logic                done;
  logic                matrices_valid;
  modport master (
    output start, abort, matrix_size, in_valid, in_data,
    input  in_ready, raw_matrix_a, raw_matrix_b, size_out, busy, done, matrices_valid
  );
  modport slave (
    input  start, abort, matrix_size, in_valid, in_data,
    output in_ready, raw_matrix_a, raw_matrix_b, size_out, busy, done, matrices_valid
  );
endinterface

// File: rtl/matrix_loader_slot_writer.sv
// matrix_slot_writer: packed matrix register written one element at a time, with clear
module matrix_slot_writer
  import matrix_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                clr_i,
  input  logic                we_i,
  input  logic [4:0]          idx_i,
  input  logic [ELEM_W-1:0]   data_i,
  output logic [PACKED_W-1:0] mat_o
);
  logic [PACKED_W-1:0] mat_q;
  logic [7:0]          base;
  assign base  = {idx_i, 3'b000};
  assign mat_o = mat_q;
  // clear wins over a write; otherwise drop the element into slot idx_i
  always_ff @(posedge clk or posedge reset)
    if (reset) mat_q <= '0;
    else if (clr_i) mat_q <= '0;
    else if (we_i) mat_q[base +: ELEM_W] <= data_i;
endmodule

// File: rtl/matrix_loader.sv
// matrix_loader: assembles operand matrices A then B from a signed element stream
module matrix_loader
  import matrix_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  matrix_loader_if.slave  bus
);
  ld_state_t  state_q;
  logic [4:0] count_q;
  logic [1:0] size_q;
  logic       in_ready_q, busy_q, done_q, mv_q;
  logic       load_go, accept, last, we_a, we_b;
  assign load_go = state_q == S_IDLE && bus.start && !bus.abort;
  assign accept  = bus.in_valid && in_ready_q && !bus.abort;
  assign last    = count_q == dim_elems(size_q) - 5'd1;
  assign we_a    = accept && state_q == S_LOAD_A;
  assign we_b    = accept && state_q == S_LOAD_B;
  // load sequencer; in_ready mirrors the load states from a register, never from in_valid
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      size_q     <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mv_q       <= 1'b0;
    end else if (bus.abort) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mv_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE:
          if (bus.start) begin
            size_q     <= bus.matrix_size;
            count_q    <= '0;
            mv_q       <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= S_LOAD_A;
          end
        S_LOAD_A:
          if (accept) begin
            count_q <= last ? 5'd0 : count_q + 5'd1;
            if (last) state_q <= S_LOAD_B;
          end
        S_LOAD_B:
          if (accept) begin
            count_q <= last ? 5'd0 : count_q + 5'd1;
            if (last) begin
              state_q    <= S_DONE;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              mv_q       <= 1'b1;
            end
          end
        default: state_q <= S_IDLE;
      endcase
    end
  matrix_slot_writer u_a (
    .clk(clk), .reset(reset), .clr_i(load_go), .we_i(we_a),
    .idx_i(count_q), .data_i(bus.in_data), .mat_o(bus.raw_matrix_a)
  );
  matrix_slot_writer u_b (
    .clk(clk), .reset(reset), .clr_i(load_go), .we_i(we_b),
    .idx_i(count_q), .data_i(bus.in_data), .mat_o(bus.raw_matrix_b)
  );
  assign bus.in_ready       = in_ready_q;
  assign bus.size_out       = size_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.matrices_valid = mv_q;
endmodule

// File: tb/tb_matrix_loader.sv
// tb_matrix_loader: directed checks of load sequencing, packing, abort and reset
module tb_matrix_loader;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  int   done_cnt;
  logic busy_ok;
  logic [199:0] exp_a, exp_b;
  matrix_loader_if bus();
  matrix_loader dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic beat(input logic [7:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    tick();
  endtask
  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.matrix_size = 2'd0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'd0;
    tick();
    tick();
    chk("rst_a", bus.raw_matrix_a, '0);
    chk("rst_b", bus.raw_matrix_b, '0);
    chk("rst_flags", {bus.in_ready, bus.busy, bus.done, bus.matrices_valid, bus.size_out}, 6'd0);
    reset = 1'b0;
    tick();
    chk("idle_ready", bus.in_ready, 1'b0);
    // 2x2 load, in_valid held high
    bus.matrix_size = 2'b00;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("2x2_busy_ready", {bus.busy, bus.in_ready}, 2'b11);
    for (int i = 1; i <= 8; i++) begin
      beat(8'(i));
      if (i == 7) chk("2x2_done_early", bus.done, 1'b0);
    end
    bus.in_valid = 1'b0;
    chk("2x2_done", bus.done, 1'b1);
    chk("2x2_a", bus.raw_matrix_a, 200'h04030201);
    chk("2x2_b", bus.raw_matrix_b, 200'h08070605);
    chk("2x2_flags", {bus.matrices_valid, bus.busy, bus.in_ready}, 3'b100);
    tick();
    chk("2x2_after", {bus.done, bus.matrices_valid, bus.in_ready}, 3'b010);
    // 5x5 load with in_valid toggling
    bus.matrix_size = 2'b11;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    busy_ok = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 50; k++) begin
      bus.in_valid = 1'b0;
      tick();
      if (!bus.busy) busy_ok = 1'b0;
      if (bus.done) done_cnt++;
      beat(k < 25 ? 8'(k) : 8'hFF);
      if (k < 49 && !bus.busy) busy_ok = 1'b0;
      if (bus.done) done_cnt++;
    end
    bus.in_valid = 1'b0;
    chk("5x5_done", bus.done, 1'b1);
    tick();
    if (bus.done) done_cnt++;
    chk("5x5_done_once", 200'(done_cnt), 200'd1);
    chk("5x5_busy_held", busy_ok, 1'b1);
    chk("5x5_a_top", bus.raw_matrix_a[199:192], 8'd24);
    exp_a = '0;
    for (int n = 0; n < 25; n++) exp_a[n*8 +: 8] = 8'(n);
    exp_b = {200{1'b1}};
    chk("5x5_a", bus.raw_matrix_a, exp_a);
    chk("5x5_b", bus.raw_matrix_b, exp_b);
    // abort after 5 A beats of a 3x3 load
    bus.matrix_size = 2'b01;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) beat(8'hA0 + 8'(i));
    bus.in_valid = 1'b0;
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_flags", {bus.in_ready, bus.matrices_valid, bus.busy, bus.done}, 4'b0000);
    bus.matrix_size = 2'b00;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) beat(8'h10 + 8'(i));
    for (int i = 0; i < 4; i++) beat(8'hF0 + 8'(i));
    bus.in_valid = 1'b0;
    chk("reload_done", bus.done, 1'b1);
    chk("reload_a", bus.raw_matrix_a, 200'h13121110);
    chk("reload_b", bus.raw_matrix_b, 200'hF3F2F1F0);
    chk("reload_size", bus.size_out, 2'b00);
    tick();
    // 3x3 load with a stray start during LOAD_B
    bus.matrix_size = 2'b01;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 1; i <= 9; i++) beat(8'(i));
    for (int j = 0; j < 9; j++) begin
      if (j == 3) begin
        bus.start = 1'b1;
        bus.matrix_size = 2'b10;
      end
      beat(8'h80 + 8'(j));
      bus.start = 1'b0;
      if (j == 7) chk("3x3_done_early", bus.done, 1'b0);
    end
    bus.in_valid = 1'b0;
    chk("3x3_done", bus.done, 1'b1);
    chk("3x3_size_kept", bus.size_out, 2'b01);
    chk("3x3_a", bus.raw_matrix_a, 200'h090807060504030201);
    chk("3x3_b", bus.raw_matrix_b, 200'h888786858483828180);
    // back-to-back start right after done
    bus.matrix_size = 2'b00;
    bus.start = 1'b1;
    tick();
    chk("b2b_idle", {bus.matrices_valid, bus.in_ready, bus.done}, 3'b100);
    tick();
    bus.start = 1'b0;
    chk("b2b_flags", {bus.matrices_valid, bus.busy, bus.size_out}, 4'b0100);
    chk("b2b_a_clr", bus.raw_matrix_a, '0);
    chk("b2b_b_clr", bus.raw_matrix_b, '0);
    // async reset between edges during LOAD_A
    beat(8'h55);
    beat(8'h55);
    bus.in_valid = 1'b0;
    chk("pre_rst_a", bus.raw_matrix_a, 200'h5555);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_a", bus.raw_matrix_a, '0);
    chk("arst_b", bus.raw_matrix_b, '0);
    chk("arst_flags", {bus.in_ready, bus.busy, bus.done, bus.matrices_valid, bus.size_out}, 6'd0);
    tick();
    reset = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    tick();
    chk("post_rst_idle", {bus.in_ready, bus.busy}, 2'b00);
    bus.in_valid = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
